// File: rtl/serial_adder_tx.sv
// ============================================================================
// Module   : serial_adder_tx
// Purpose  : Bit-serial add/subtract, one full-adder slice, LSB-first output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_tx #(
    parameter int D_N = 32
) (
    input  logic           w_clk,
    input  logic           w_rst,
    input  logic           w_start,
    input  logic           w_sub,
    input  logic [D_N-1:0] w_a,
    input  logic [D_N-1:0] w_b,
    output logic           w_busy,
    output logic           w_sout,
    output logic           w_sout_vld,
    output logic           w_done,
    output logic [D_N-1:0] w_s,
    output logic           w_cout
);

    localparam int              c_CW   = (D_N > 2) ? $clog2(D_N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(D_N - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [D_N-1:0]  r_a;
    logic [D_N-1:0]  r_b;
    logic [D_N-1:0]  r_s;
    logic [c_CW-1:0] r_cnt;
    logic            r_carry;
    logic            r_sout;
    logic            r_vld;
    logic            r_done;
    logic            r_cout;

    logic            w_last;
    logic            w_sum;
    logic            w_cy;

    assign w_last = (r_cnt == c_LAST);
    assign w_sum  = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cy   = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = RUN;
            RUN:     if (w_last)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sout  <= 1'b0;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            r_vld  <= 1'b0;
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (w_start) begin
                    // Subtraction is A + ~B + 1: the +1 rides in on the carry.
                    r_a     <= w_a;
                    r_b     <= w_sub ? ~w_b : w_b;
                    r_carry <= w_sub;
                    r_cnt   <= '0;
                    r_s     <= '0;
                end
            end else begin
                r_sout  <= w_sum;
                r_vld   <= 1'b1;
                r_carry <= w_cy;
                r_a     <= {1'b0, r_a[D_N-1:1]};
                r_b     <= {1'b0, r_b[D_N-1:1]};
                r_s     <= {w_sum, r_s[D_N-1:1]};
                if (w_last) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                    r_cout <= w_cy;
                end else begin
                    r_cnt  <= r_cnt + c_CW'(1);
                end
            end
        end
    end

    assign w_busy     = (r_state == RUN);
    assign w_sout     = r_sout;
    assign w_sout_vld = r_vld;
    assign w_done     = r_done;
    assign w_s        = r_s;
    assign w_cout     = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_tx.sv
// ============================================================================
// Module   : tb_serial_adder_tx
// Purpose  : Randomized self-checking bench for serial_adder_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_tx;

    localparam int D_N   = 32;
    localparam int c_NR  = 20;

    logic           w_clk = 1'b0;
    logic           w_rst;
    logic           w_start;
    logic           w_sub;
    logic [D_N-1:0] w_a;
    logic [D_N-1:0] w_b;
    logic           w_busy;
    logic           w_sout;
    logic           w_sout_vld;
    logic           w_done;
    logic [D_N-1:0] w_s;
    logic           w_cout;

    int n_vec = 0;
    int n_err = 0;

    serial_adder_tx #(.D_N(D_N)) u_dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_start    (w_start),
        .w_sub      (w_sub),
        .w_a        (w_a),
        .w_b        (w_b),
        .w_busy     (w_busy),
        .w_sout     (w_sout),
        .w_sout_vld (w_sout_vld),
        .w_done     (w_done),
        .w_s        (w_s),
        .w_cout     (w_cout)
    );

    always #5 w_clk = ~w_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [D_N-1:0] a, input logic [D_N-1:0] b, input logic sub);
        w_start = 1'b1;
        w_a     = a;
        w_b     = b;
        w_sub   = sub;
    endtask

    // Caller has just driven the start at a falling edge. Follows the
    // operation through its done cycle, optionally chaining the next start.
    task automatic run_op(input logic [D_N-1:0] a, input logic [D_N-1:0] b, input logic sub,
                          input bit poke_busy, input bit chain,
                          input logic [D_N-1:0] a2, input logic [D_N-1:0] b2, input logic sub2);
        logic [D_N-1:0] exp_s;
        logic           exp_c;
        if (sub) begin
            exp_s = a - b;
            exp_c = (a >= b);
        end else begin
            {exp_c, exp_s} = {1'b0, a} + {1'b0, b};
        end
        for (int n = 1; n <= D_N + 1; n++) begin
            @(negedge w_clk);
            if (n == 1) begin
                w_start = 1'b0;
                w_a     = $urandom;
                w_b     = $urandom;
                w_sub   = 1'($urandom);
            end
            if (poke_busy && n == 5) drive(32'h1234_5678, 32'h1234_5678, 1'b0);
            if (poke_busy && n == 6) w_start = 1'b0;
            chk("busy", w_busy, 64'(n <= D_N));
            chk("sout_vld", w_sout_vld, 64'(n >= 2));
            chk("done", w_done, 64'(n == D_N + 1));
            if (n >= 2) chk("sout_bit", w_sout, exp_s[n-2]);
        end
        chk("s", w_s, exp_s);
        chk("cout", w_cout, exp_c);
        if (chain) drive(a2, b2, sub2);
    endtask

    logic [D_N-1:0] ra [c_NR];
    logic [D_N-1:0] rb [c_NR];
    logic           rs [c_NR];
    bit             rch[c_NR];

    initial begin
        w_rst   = 1'b1;
        w_start = 1'b0;
        w_sub   = 1'b0;
        w_a     = '0;
        w_b     = '0;
        repeat (3) @(negedge w_clk);
        w_rst = 1'b0;
        chk("rst_busy", w_busy, 0);
        chk("rst_vld", w_sout_vld, 0);
        chk("rst_done", w_done, 0);
        chk("rst_sout", w_sout, 0);
        chk("rst_s", w_s, 0);
        chk("rst_cout", w_cout, 0);

        // Directed cases
        @(negedge w_clk); drive(3, 10, 1'b0);
        run_op(3, 10, 1'b0, 0, 0, 0, 0, 1'b0);
        @(negedge w_clk); drive(10, 3, 1'b1);
        run_op(10, 3, 1'b1, 0, 0, 0, 0, 1'b0);
        @(negedge w_clk); drive(3, 10, 1'b1);
        run_op(3, 10, 1'b1, 0, 0, 0, 0, 1'b0);
        @(negedge w_clk); drive(32'hFFFF_FFFF, 1, 1'b0);
        run_op(32'hFFFF_FFFF, 1, 1'b0, 0, 0, 0, 0, 1'b0);

        // Start while busy is ignored; then chain a start in the done cycle
        @(negedge w_clk); drive(3, 10, 1'b0);
        run_op(3, 10, 1'b0, 1, 1, 1, 1, 1'b0);
        run_op(1, 1, 1'b0, 0, 0, 0, 0, 1'b0);

        // Reset mid-operation
        @(negedge w_clk); drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(negedge w_clk); w_start = 1'b0;
        repeat (16) @(negedge w_clk);
        chk("mid_vld", w_sout_vld, 1);
        w_rst = 1'b1;
        @(negedge w_clk);
        w_rst = 1'b0;
        chk("mrst_busy", w_busy, 0);
        chk("mrst_vld", w_sout_vld, 0);
        chk("mrst_done", w_done, 0);
        chk("mrst_sout", w_sout, 0);
        chk("mrst_s", w_s, 0);
        chk("mrst_cout", w_cout, 0);
        repeat (20) begin
            @(negedge w_clk);
            chk("mrst_no_done", w_done, 0);
        end
        drive(5, 6, 1'b0);
        run_op(5, 6, 1'b0, 0, 0, 0, 0, 1'b0);

        // Randomized operations, some back-to-back, some with A==B
        for (int i = 0; i < c_NR; i++) begin
            ra[i]  = $urandom;
            rb[i]  = ($urandom_range(0, 4) == 0) ? ra[i] : D_N'($urandom);
            rs[i]  = 1'($urandom);
            rch[i] = 1'($urandom);
        end
        for (int i = 0; i < c_NR; i++) begin
            if (i == 0 || !rch[i-1]) begin
                @(negedge w_clk);
                drive(ra[i], rb[i], rs[i]);
            end
            run_op(ra[i], rb[i], rs[i], 0, (i < c_NR - 1) && rch[i],
                   ra[(i+1)%c_NR], rb[(i+1)%c_NR], rs[(i+1)%c_NR]);
        end

        repeat (2) @(negedge w_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
